// File: rtl/regfile_scan_checker.sv
// Sweeps r0..r(NUM_REGS-1) through the regfile source port, checks the walking-one
// pattern, reports pass/errors/first failing index, then mirrors a switch-selected register.
module regfile_scan_checker #(
  parameter int BIT_WIDTH = 16,
  parameter int SEL_WIDTH = 4,
  parameter int NUM_REGS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] userInput,
  input  logic [BIT_WIDTH-1:0] rdData,
  output logic [SEL_WIDTH-1:0] SrcAddr,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SEL_WIDTH:0]   errCount,
  output logic [SEL_WIDTH-1:0] firstErrIdx,
  output logic [BIT_WIDTH-1:0] dispData,
  output logic [1:0]           outputState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CHECK = 2'b01,
    S_SHOW  = 2'b10
  } state_t;

  state_t               r_state;
  logic [SEL_WIDTH-1:0] r_idx;
  logic [SEL_WIDTH-1:0] r_src_addr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_pass;
  logic [SEL_WIDTH:0]   r_err_count;
  logic [SEL_WIDTH-1:0] r_first_err_idx;
  logic [BIT_WIDTH-1:0] r_disp_data;

  logic [BIT_WIDTH-1:0] w_exp;
  logic                 w_mismatch;
  logic                 w_last;
  logic [SEL_WIDTH:0]   w_err_next;
  logic                 w_start_sweep;

  // Expected walking-one; indices past BIT_WIDTH shift out to zero.
  assign w_exp         = {{(BIT_WIDTH-1){1'b0}}, 1'b1} << r_idx;
  assign w_mismatch    = (rdData != w_exp);
  assign w_last        = (r_idx == SEL_WIDTH'(NUM_REGS - 1));
  assign w_err_next    = r_err_count + (SEL_WIDTH+1)'(w_mismatch);
  assign w_start_sweep = start && ((r_state == S_IDLE) || (r_state == S_SHOW));

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_idx           <= '0;
      r_src_addr      <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_disp_data     <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_CHECK) begin
        if (w_mismatch) begin
          r_err_count <= w_err_next;
          if (r_err_count == '0) r_first_err_idx <= r_idx;
        end
        if (w_last) begin
          r_done  <= 1'b1;
          r_pass  <= (w_err_next == '0);
          r_state <= S_SHOW;
          r_busy  <= 1'b0;
        end else begin
          r_idx      <= r_idx + 1'b1;
          r_src_addr <= r_idx + 1'b1;
        end
      end else if (w_start_sweep) begin
        // A new sweep clears the previous verdict; dispData keeps its last value.
        r_idx           <= '0;
        r_src_addr      <= '0;
        r_err_count     <= '0;
        r_pass          <= 1'b0;
        r_first_err_idx <= '0;
        r_state         <= S_CHECK;
        r_busy          <= 1'b1;
      end else if (r_state == S_SHOW) begin
        r_src_addr  <= userInput;
        r_disp_data <= rdData;
      end else if (r_state == S_IDLE) begin
        r_src_addr <= '0;
      end else begin
        // Unused encoding 2'b11 recovers to IDLE.
        r_state    <= S_IDLE;
        r_src_addr <= '0;
        r_busy     <= 1'b0;
      end
    end
  end

  assign SrcAddr     = r_src_addr;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign errCount    = r_err_count;
  assign firstErrIdx = r_first_err_idx;
  assign dispData    = r_disp_data;
  assign outputState = r_state;

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Directed bench for regfile_scan_checker: a behavioural regfile feeds rdData and
// each sweep is checked cycle by cycle against hand-computed values.
module tb_regfile_scan_checker;

  localparam int BW = 16;
  localparam int SW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [SW-1:0] userInput;
  logic [BW-1:0] rdData;
  logic [SW-1:0] SrcAddr;
  logic          busy;
  logic          done;
  logic          pass;
  logic [SW:0]   errCount;
  logic [SW-1:0] firstErrIdx;
  logic [BW-1:0] dispData;
  logic [1:0]    outputState;

  logic [BW-1:0] mem [NR];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign rdData = mem[SrcAddr];

  regfile_scan_checker #(.BIT_WIDTH(BW), .SEL_WIDTH(SW), .NUM_REGS(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .userInput   (userInput),
    .rdData      (rdData),
    .SrcAddr     (SrcAddr),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .errCount    (errCount),
    .firstErrIdx (firstErrIdx),
    .dispData    (dispData),
    .outputState (outputState)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_walking_one();
    for (int i = 0; i < NR; i++) mem[i] = BW'(1) << i;
  endtask

  // Pulses start, then follows the sweep edge by edge through done's fall.
  task automatic run_sweep(input int exp_errs, input int exp_first, input bit exp_pass,
                           input bit chk_disp, input logic [BW-1:0] exp_disp,
                           input bit poke_start);
    start = 1'b1;
    tick();                          // edge T
    start = 1'b0;
    check("T_busy",     busy, 1);
    check("T_state",    outputState, 2'b01);
    check("T_src",      SrcAddr, 0);
    check("T_errclr",   errCount, 0);
    check("T_passclr",  pass, 0);
    check("T_firstclr", firstErrIdx, 0);
    if (chk_disp) check("T_disp_hold", dispData, exp_disp);
    for (int k = 1; k < NR; k++) begin
      tick();                        // edge T+k
      check($sformatf("src_%0d", k), SrcAddr, k);
      check($sformatf("nodone_%0d", k), done, 0);
      if (poke_start && k == 5) start = 1'b1;
      if (poke_start && k == 6) start = 1'b0;
    end
    tick();                          // edge T+NR
    check("done_hi",   done, 1);
    check("done_pass", pass, exp_pass);
    check("done_errs", errCount, exp_errs);
    if (exp_errs != 0) check("done_first", firstErrIdx, exp_first);
    check("done_state", outputState, 2'b10);
    check("done_busy",  busy, 0);
    tick();                          // edge T+NR+1
    check("done_lo",    done, 0);
    check("show_errs",  errCount, exp_errs);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    start = 1'b0;
    userInput = '0;
    load_walking_one();
    tick();
    tick();
    check("rst_src",   SrcAddr, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_pass",  pass, 0);
    check("rst_errs",  errCount, 0);
    check("rst_first", firstErrIdx, 0);
    check("rst_disp",  dispData, 0);
    check("rst_state", outputState, 2'b00);
    @(negedge clk) reset = 1'b0;
    tick();
    tick();
    check("idle_state", outputState, 2'b00);
    check("idle_src",   SrcAddr, 0);

    // Clean pattern passes.
    run_sweep(0, 0, 1'b1, 1'b0, '0, 1'b0);

    // SHOW mode: two-edge display latency.
    userInput = 4'd7;
    tick();
    check("show_src7", SrcAddr, 7);
    tick();
    check("show_disp7", dispData, 16'h0080);
    userInput = 4'd15;
    tick();
    check("show_src15", SrcAddr, 15);
    tick();
    check("show_disp15", dispData, 16'h8000);
    check("show_pass_stable", pass, 1);
    check("show_busy", busy, 0);

    // Single bad register; sweep restarted from SHOW keeps dispData.
    userInput = 4'd5;
    tick();
    tick();
    check("show_disp5", dispData, 16'h0020);
    mem[5] = 16'h0000;
    run_sweep(1, 5, 1'b0, 1'b1, 16'h0020, 1'b0);

    // Three corrupted registers.
    load_walking_one();
    mem[3]  = 16'h0000;
    mem[9]  = 16'h0001;
    mem[15] = 16'h7FFF;
    run_sweep(3, 3, 1'b0, 1'b0, '0, 1'b0);

    // All zero: full-scale count; start during CHECK is ignored.
    for (int i = 0; i < NR; i++) mem[i] = '0;
    run_sweep(16, 0, 1'b0, 1'b0, '0, 1'b1);

    // Reset mid-sweep at idx 8.
    load_walking_one();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("mid_src8", SrcAddr, 8);
    reset = 1'b1;
    #1;
    check("abort_src",   SrcAddr, 0);
    check("abort_busy",  busy, 0);
    check("abort_state", outputState, 2'b00);
    check("abort_errs",  errCount, 0);
    check("abort_pass",  pass, 0);
    check("abort_disp",  dispData, 0);
    tick();
    @(negedge clk) reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_idle",    outputState, 2'b00);

    // Normal sweep after reset.
    run_sweep(0, 0, 1'b1, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
